// File: rtl/mac_pe_v2_if.sv
// mac_pe_v2_if -- operand, forwarding and drain-chain bundle of one
// systolic processing element.
//
// Members:
//   in_a / in_a_valid / in_a_last   row operand from the left neighbour
//   in_b / in_b_valid               column operand from the upper neighbour
//   out_a / out_a_valid / out_a_last registered row operand to the right
//   out_b / out_b_valid             registered column operand downward
//   c_in / c_in_valid               drain-chain data from the upper PE
//   c_out / c_out_valid             drain-chain data to the lower PE
//   tile_active                     a tile is partially accumulated
//   err_overflow                    sticky: a tile result was dropped
//
// Modports:
//   master -- the environment / neighbours driving the PE
//   slave  -- the PE itself
interface mac_pe_v2_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32
);
    logic [DATA_W-1:0] in_a;
    logic              in_a_valid;
    logic              in_a_last;
    logic [DATA_W-1:0] in_b;
    logic              in_b_valid;
    logic [DATA_W-1:0] out_a;
    logic              out_a_valid;
    logic              out_a_last;
    logic [DATA_W-1:0] out_b;
    logic              out_b_valid;
    logic [OUT_W-1:0]  c_in;
    logic              c_in_valid;
    logic [OUT_W-1:0]  c_out;
    logic              c_out_valid;
    logic              tile_active;
    logic              err_overflow;

    modport master (
        output in_a, in_a_valid, in_a_last, in_b, in_b_valid, c_in, c_in_valid,
        input  out_a, out_a_valid, out_a_last, out_b, out_b_valid,
        input  c_out, c_out_valid, tile_active, err_overflow
    );

    modport slave (
        input  in_a, in_a_valid, in_a_last, in_b, in_b_valid, c_in, c_in_valid,
        output out_a, out_a_valid, out_a_last, out_b, out_b_valid,
        output c_out, c_out_valid, tile_active, err_overflow
    );
endinterface

// File: rtl/mac_pe_v2.sv
// mac_pe_v2 -- output-stationary multiply-accumulate processing element.
//
// Forwards operands right (a) and down (b) with one registered stage,
// accumulates matched valid operand pairs into an ACC_W accumulator, and at
// the end of each tile converts the sum to OUT_W bits and offers it to a
// single-entry hold buffer that drains onto a shared column chain. Upstream
// drain traffic always wins the chain slot.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset (0 = reset)
//   pe   mac_pe_v2_if.slave bundle (operands, forwarding, drain chain, status)
module mac_pe_v2 #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int OUT_W  = 32,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    mac_pe_v2_if.slave pe
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

    // One extra bit per operand lets a single signed multiplier cover both
    // modes: the top bit is the sign in SIGNED mode and 0 otherwise.
    logic signed [DATA_W:0]     a_ext;
    logic signed [DATA_W:0]     b_ext;
    logic signed [2*DATA_W+1:0] prod_full;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [OUT_W-1:0]           result;
    logic                       fire, new_res, grant;

    logic [DATA_W-1:0] out_a_q, out_b_q;
    logic              out_a_valid_q, out_a_last_q, out_b_valid_q;
    logic [OUT_W-1:0]  c_out_q, hold_q;
    logic              c_out_valid_q, tile_active_q, err_q;
    hold_state_t       state_q;

    // Saturating / truncating ACC_W -> OUT_W conversion.
    function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] s);
        logic [ACC_W-1:0] hi;
        logic [OUT_W-1:0] r;
        hi = '0;
        r  = s[OUT_W-1:0];
        if (SAT) begin
            if (SIGNED) begin
                // Fits iff every bit from OUT_W-1 upward equals the sign.
                hi = ACC_W'($signed(s) >>> (OUT_W - 1));
                if (hi != '0 && hi != '1)
                    r = s[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                hi = s >> OUT_W;
                if (hi != '0)
                    r = '1;
            end
        end
        return r;
    endfunction

    always_comb begin
        a_ext     = {(SIGNED && pe.in_a[DATA_W-1]), pe.in_a};
        b_ext     = {(SIGNED && pe.in_b[DATA_W-1]), pe.in_b};
        prod_full = (2*DATA_W+2)'(a_ext) * (2*DATA_W+2)'(b_ext);
        // Signed cast extends with the sign bit, which is 0 for unsigned mode.
        prod_ext  = ACC_W'(prod_full);
        acc_d     = acc_q + prod_ext;
        result    = conv(acc_d);
        fire      = pe.in_a_valid && pe.in_b_valid;
        new_res   = fire && pe.in_a_last;
        grant     = !pe.c_in_valid && (state_q == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_a_q       <= '0;
            out_a_valid_q <= 1'b0;
            out_a_last_q  <= 1'b0;
            out_b_q       <= '0;
            out_b_valid_q <= 1'b0;
            acc_q         <= '0;
            tile_active_q <= 1'b0;
            hold_q        <= '0;
            state_q       <= EMPTY;
            c_out_q       <= '0;
            c_out_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            out_a_q       <= pe.in_a;
            out_a_valid_q <= pe.in_a_valid;
            out_a_last_q  <= pe.in_a_last;
            out_b_q       <= pe.in_b;
            out_b_valid_q <= pe.in_b_valid;

            if (fire) begin
                if (pe.in_a_last) begin
                    acc_q         <= '0;
                    tile_active_q <= 1'b0;
                end else begin
                    acc_q         <= acc_d;
                    tile_active_q <= 1'b1;
                end
            end

            // Drain slot: upstream first, then our held result.
            if (pe.c_in_valid) begin
                c_out_q       <= pe.c_in;
                c_out_valid_q <= 1'b1;
            end else if (state_q == FULL) begin
                c_out_q       <= hold_q;
                c_out_valid_q <= 1'b1;
            end else begin
                c_out_valid_q <= 1'b0;
            end

            case (state_q)
                EMPTY: begin
                    if (new_res) begin
                        hold_q  <= result;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (grant) begin
                        if (new_res)
                            hold_q <= result;
                        else
                            state_q <= EMPTY;
                    end else if (new_res) begin
                        // Slot denied and buffer occupied: the new result is lost.
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign pe.out_a        = out_a_q;
    assign pe.out_a_valid  = out_a_valid_q;
    assign pe.out_a_last   = out_a_last_q;
    assign pe.out_b        = out_b_q;
    assign pe.out_b_valid  = out_b_valid_q;
    assign pe.c_out        = c_out_q;
    assign pe.c_out_valid  = c_out_valid_q;
    assign pe.tile_active  = tile_active_q;
    assign pe.err_overflow = err_q;
endmodule

// File: tb/tb_mac_pe_v2.sv
// tb_mac_pe_v2 -- bench for mac_pe_v2. Three instances (signed/saturating,
// signed/wrapping, unsigned/saturating) receive identical stimulus; tile
// results are predicted from plain 64-bit integer arithmetic.
module tb_mac_pe_v2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] in_a = '0, in_b = '0, c_in = '0;
    logic        in_a_valid = 1'b0, in_a_last = 1'b0, in_b_valid = 1'b0, c_in_valid = 1'b0;

    mac_pe_v2_if #(.DATA_W(32), .OUT_W(32)) if11 ();
    mac_pe_v2_if #(.DATA_W(32), .OUT_W(32)) if10 ();
    mac_pe_v2_if #(.DATA_W(32), .OUT_W(32)) if01 ();

    assign if11.in_a = in_a;  assign if11.in_a_valid = in_a_valid;  assign if11.in_a_last = in_a_last;
    assign if11.in_b = in_b;  assign if11.in_b_valid = in_b_valid;
    assign if11.c_in = c_in;  assign if11.c_in_valid = c_in_valid;
    assign if10.in_a = in_a;  assign if10.in_a_valid = in_a_valid;  assign if10.in_a_last = in_a_last;
    assign if10.in_b = in_b;  assign if10.in_b_valid = in_b_valid;
    assign if10.c_in = c_in;  assign if10.c_in_valid = c_in_valid;
    assign if01.in_a = in_a;  assign if01.in_a_valid = in_a_valid;  assign if01.in_a_last = in_a_last;
    assign if01.in_b = in_b;  assign if01.in_b_valid = in_b_valid;
    assign if01.c_in = c_in;  assign if01.c_in_valid = c_in_valid;

    mac_pe_v2 #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .SIGNED(1'b1), .SAT(1'b1))
        u11 (.clk(clk), .rst(rst), .pe(if11));
    mac_pe_v2 #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .SIGNED(1'b1), .SAT(1'b0))
        u10 (.clk(clk), .rst(rst), .pe(if10));
    mac_pe_v2 #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .SIGNED(1'b0), .SAT(1'b1))
        u01 (.clk(clk), .rst(rst), .pe(if01));

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: exact tile sums in 64-bit integers, converted by
    // comparing against the output range.
    longint          ssum = 0;
    longint unsigned usum = 0;
    logic [31:0]     e11 = '0, e10 = '0, e01 = '0;

    function automatic logic [31:0] conv_ss(input longint s);
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] conv_us(input longint unsigned u);
        if (u > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return u[31:0];
    endfunction

    task automatic mreset();
        ssum = 0;
        usum = 0;
    endtask

    task automatic mfire(input logic [31:0] a, input logic [31:0] b, input logic last);
        ssum += longint'($signed(a)) * longint'($signed(b));
        usum += 64'(a) * 64'(b);
        if (last) begin
            e11 = conv_ss(ssum);
            e10 = ssum[31:0];
            e01 = conv_us(usum);
            mreset();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of operands, update the model on a fire, check forwarding.
    task automatic cyc(input logic [31:0] a, input logic av, input logic al,
                       input logic [31:0] b, input logic bv);
        in_a = a; in_a_valid = av; in_a_last = al; in_b = b; in_b_valid = bv;
        if (av && bv) mfire(a, b, al);
        tick();
        chk("fwd_out_a", if11.out_a, a);
        chk("fwd_out_a_valid", if11.out_a_valid, av);
        chk("fwd_out_b_valid", if11.out_b_valid, bv);
        in_a = '0; in_a_valid = 1'b0; in_a_last = 1'b0; in_b = '0; in_b_valid = 1'b0;
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_v11"}, if11.c_out_valid, 1'b1);
        chk({tag, "_c11"}, if11.c_out, e11);
        chk({tag, "_v10"}, if10.c_out_valid, 1'b1);
        chk({tag, "_c10"}, if10.c_out, e10);
        chk({tag, "_v01"}, if01.c_out_valid, 1'b1);
        chk({tag, "_c01"}, if01.c_out, e01);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] ext [4];
        ext[0] = 32'h7FFF_FFFF; ext[1] = 32'h8000_0000; ext[2] = 32'hFFFF_FFFF; ext[3] = 32'h0;
        if ($urandom_range(0, 3) == 0) return ext[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        // Reset with every input active.
        rst = 1'b0;
        in_a = 32'h5; in_a_valid = 1'b1; in_a_last = 1'b1;
        in_b = 32'h6; in_b_valid = 1'b1; c_in = 32'h7; c_in_valid = 1'b1;
        repeat (3) tick();
        chk("rst_out_a", if11.out_a, 0);
        chk("rst_out_a_valid", if11.out_a_valid, 0);
        chk("rst_out_a_last", if11.out_a_last, 0);
        chk("rst_out_b", if11.out_b, 0);
        chk("rst_out_b_valid", if11.out_b_valid, 0);
        chk("rst_c_out", if11.c_out, 0);
        chk("rst_c_out_valid", if11.c_out_valid, 0);
        chk("rst_tile_active", if11.tile_active, 0);
        chk("rst_err", if11.err_overflow, 0);
        chk("rst_c_out_valid01", if01.c_out_valid, 0);
        in_a = '0; in_a_valid = 1'b0; in_a_last = 1'b0; in_b = '0; in_b_valid = 1'b0;
        c_in = '0; c_in_valid = 1'b0;
        rst = 1'b1;
        mreset();
        tick();

        // Basic signed tile: 12 - 10 - 7 = -5.
        cyc(32'd3, 1, 0, 32'd4, 1);
        chk("t2_tile_active_first", if11.tile_active, 1);
        cyc(32'hFFFF_FFFE, 1, 0, 32'd5, 1);
        cyc(32'd7, 1, 1, 32'hFFFF_FFFF, 1);
        chk("t2_tile_active_last", if11.tile_active, 0);
        chk("t2_no_early_valid", if11.c_out_valid, 0);
        tick();
        chk_result("t2");
        chk("t2_const", if11.c_out, 32'hFFFF_FFFB);
        tick();
        chk("t2_pulse_end", if11.c_out_valid, 0);
        chk("t2_c_out_holds", if11.c_out, 32'hFFFF_FFFB);

        // Extreme products: saturation vs wrap vs unsigned saturation.
        cyc(32'h7FFF_FFFF, 1, 0, 32'h7FFF_FFFF, 1);
        cyc(32'h7FFF_FFFF, 1, 1, 32'h7FFF_FFFF, 1);
        tick();
        chk_result("t3");
        chk("t3_sat_signed", if11.c_out, 32'h7FFF_FFFF);
        chk("t3_wrap", if10.c_out, 32'h0000_0002);
        chk("t3_sat_unsigned", if01.c_out, 32'hFFFF_FFFF);
        tick();

        // Bubbles and unqualified last markers must not disturb the sum.
        cyc(32'd3, 1, 0, 32'd4, 1);
        cyc(32'd100, 1, 0, 32'd0, 0);
        cyc(32'd0, 0, 1, 32'd9, 1);
        cyc(32'hFFFF_FFFE, 1, 0, 32'd5, 1);
        cyc(32'd55, 1, 1, 32'd0, 0);
        chk("t4_tile_still_active", if11.tile_active, 1);
        chk("t4_no_result", if11.c_out_valid, 0);
        cyc(32'd7, 1, 1, 32'hFFFF_FFFF, 1);
        tick();
        chk_result("t4");
        chk("t4_const", if11.c_out, 32'hFFFF_FFFB);
        tick();

        // Contention: upstream wins, the local result waits.
        c_in = 32'd10; c_in_valid = 1'b1;
        cyc(32'd9, 1, 1, 32'd11, 1);
        chk("t5a_c0", if11.c_out, 32'd10);
        c_in = 32'd11; tick();
        chk("t5a_c1", if11.c_out, 32'd11);
        c_in = 32'd12; tick();
        chk("t5a_c2", if11.c_out, 32'd12);
        c_in_valid = 1'b0; c_in = '0; tick();
        chk("t5a_c3", if11.c_out, 32'd99);
        chk("t5a_v3", if11.c_out_valid, 1);
        chk("t5a_c3_u01", if01.c_out, 32'd99);
        tick();
        chk("t5a_v4", if11.c_out_valid, 0);
        chk("t5a_err", if11.err_overflow, 0);

        // Contention with a second result while the first is held and denied.
        c_in = 32'd10; c_in_valid = 1'b1;
        cyc(32'd9, 1, 1, 32'd11, 1);
        chk("t5b_c0", if11.c_out, 32'd10);
        c_in = 32'd11;
        cyc(32'd5, 1, 1, 32'd11, 1);
        chk("t5b_c1", if11.c_out, 32'd11);
        chk("t5b_err_set", if11.err_overflow, 1);
        c_in = 32'd12; tick();
        chk("t5b_c2", if11.c_out, 32'd12);
        c_in_valid = 1'b0; c_in = '0; tick();
        chk("t5b_c3", if11.c_out, 32'd99);
        chk("t5b_v3", if11.c_out_valid, 1);
        tick();
        chk("t5b_55_lost", if11.c_out_valid, 0);
        repeat (3) tick();
        chk("t5b_err_sticky", if11.err_overflow, 1);
        chk("t5b_err_sticky10", if10.err_overflow, 1);

        // Mid-tile reset discards the partial sum.
        cyc(32'd5, 1, 0, 32'd5, 1);
        cyc(32'd5, 1, 0, 32'd5, 1);
        chk("t6_active", if11.tile_active, 1);
        rst = 1'b0; tick(); rst = 1'b1;
        mreset();
        chk("t6_rst_tile", if11.tile_active, 0);
        chk("t6_rst_err", if11.err_overflow, 0);
        cyc(32'd2, 1, 1, 32'd3, 1);
        tick();
        chk_result("t6");
        chk("t6_const", if11.c_out, 32'd6);
        tick();

        // Randomised tiles with bubbles, no upstream traffic.
        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    logic av, bv;
                    av = 1'($urandom_range(0, 1));
                    bv = av ? 1'b0 : 1'($urandom_range(0, 1));
                    cyc(pick(), av, 1'($urandom_range(0, 1)), pick(), bv);
                end
                cyc(pick(), 1, (i == len - 1), pick(), 1);
            end
            chk("rnd_tile_done", if11.tile_active, 0);
            tick();
            chk_result("rnd");
            tick();
            chk("rnd_pulse_end", if11.c_out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
